// File: rtl/imem_loader.sv
// Program loader for the instruction memory: packs a big-endian byte stream into
// 32-bit words and writes them at consecutive (wrapping) addresses. Optional macro: CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_load_len,
  input  logic [7:0]            i_byte_in,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic                  o_mem_mode,
  output logic                  o_mem_write_enable,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [1:0]            o_state
);

  // Handshake: a byte transfers on a posedge where i_byte_valid && o_byte_ready;
  // the source holds i_byte_in stable until then, and ready never depends on valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2
`ifdef CHECKSUM_EN
    ,CHECK = 2'd3
`endif
  } state_t;

  state_t                r_state, w_state;
  logic                  r_byte_ready, w_byte_ready;
  logic                  r_mem_mode, w_mem_mode;
  logic                  r_we, w_we;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_data, w_data;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  r_error, w_error;
  logic [ADDR_WIDTH-1:0] r_base, w_base;
  logic [ADDR_WIDTH-1:0] r_len, w_len;
  logic [ADDR_WIDTH-1:0] r_word_idx, w_word_idx;
  logic [1:0]            r_byte_cnt, w_byte_cnt;
  logic [23:0]           r_shift, w_shift;
  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_last_idx;
`ifdef CHECKSUM_EN
  logic [7:0]            r_csum, w_csum;
`endif

  assign w_xfer     = i_byte_valid && r_byte_ready;
  // len==0 wraps to all-ones here, which is exactly the 2**ADDR_WIDTH-word case.
  assign w_last_idx = r_len - ADDR_WIDTH'(1);

  always_comb begin
    w_state      = r_state;
    w_byte_ready = r_byte_ready;
    w_mem_mode   = r_mem_mode;
    w_we         = 1'b0;
    w_addr       = r_addr;
    w_data       = r_data;
    w_busy       = r_busy;
    w_done       = r_done;
    w_error      = r_error;
    w_base       = r_base;
    w_len        = r_len;
    w_word_idx   = r_word_idx;
    w_byte_cnt   = r_byte_cnt;
    w_shift      = r_shift;
`ifdef CHECKSUM_EN
    w_csum       = r_csum;
`endif
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_base       = i_base_addr;
          w_len        = i_load_len;
          w_done       = 1'b0;
          w_error      = 1'b0;
          w_word_idx   = '0;
          w_byte_cnt   = '0;
          w_busy       = 1'b1;
          w_mem_mode   = 1'b0;
          w_byte_ready = 1'b1;
          w_state      = RECV;
`ifdef CHECKSUM_EN
          w_csum       = '0;
`endif
        end
      end
      RECV: begin
        if (w_xfer) begin
          w_shift    = {r_shift[15:0], i_byte_in};
          w_byte_cnt = r_byte_cnt + 2'd1;
`ifdef CHECKSUM_EN
          w_csum     = r_csum ^ i_byte_in;
`endif
          if (r_byte_cnt == 2'd3) begin
            w_state      = WRITE;
            w_byte_ready = 1'b0;
            w_we         = 1'b1;
            w_addr       = r_base + r_word_idx;
            w_data       = {r_shift, i_byte_in};
          end
        end
      end
      WRITE: begin
        if (r_word_idx == w_last_idx) begin
`ifdef CHECKSUM_EN
          w_state      = CHECK;
          w_byte_ready = 1'b1;
`else
          w_state      = IDLE;
          w_done       = 1'b1;
          w_busy       = 1'b0;
          w_mem_mode   = 1'b1;
`endif
        end else begin
          w_word_idx   = r_word_idx + ADDR_WIDTH'(1);
          w_byte_cnt   = '0;
          w_byte_ready = 1'b1;
          w_state      = RECV;
        end
      end
`ifdef CHECKSUM_EN
      CHECK: begin
        if (w_xfer) begin
          w_error      = (i_byte_in != r_csum);
          w_done       = 1'b1;
          w_busy       = 1'b0;
          w_mem_mode   = 1'b1;
          w_byte_ready = 1'b0;
          w_state      = IDLE;
        end
      end
`endif
      default: begin
        w_state      = IDLE;
        w_byte_ready = 1'b0;
        w_mem_mode   = 1'b1;
        w_busy       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_byte_ready <= 1'b0;
      r_mem_mode   <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_base       <= '0;
      r_len        <= '0;
      r_word_idx   <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
`ifdef CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_state      <= w_state;
      r_byte_ready <= w_byte_ready;
      r_mem_mode   <= w_mem_mode;
      r_we         <= w_we;
      r_addr       <= w_addr;
      r_data       <= w_data;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_error      <= w_error;
      r_base       <= w_base;
      r_len        <= w_len;
      r_word_idx   <= w_word_idx;
      r_byte_cnt   <= w_byte_cnt;
      r_shift      <= w_shift;
`ifdef CHECKSUM_EN
      r_csum       <= w_csum;
`endif
    end
  end

  assign o_byte_ready       = r_byte_ready;
  assign o_mem_mode         = r_mem_mode;
  assign o_mem_write_enable = r_we;
  assign o_mem_addr         = r_addr;
  assign o_mem_data_in      = r_data;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_error            = r_error;
  assign o_state            = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: models the instruction memory write port and
// checks every strobe, the status flags and the memory contents after each load.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  base_addr;
  logic [4:0]  load_len;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_mode;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mem_model [32];
  logic [4:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [4:0]  exp_addr_q [$];
  logic [31:0] exp_q [$];
  logic [7:0]  tb_xor;

  imem_loader #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .i_clock            (clk),
    .i_reset            (rst_n),
    .i_start            (start),
    .i_base_addr        (base_addr),
    .i_load_len         (load_len),
    .i_byte_in          (byte_in),
    .i_byte_valid       (byte_valid),
    .o_byte_ready       (byte_ready),
    .o_mem_mode         (mem_mode),
    .o_mem_write_enable (mem_we),
    .o_mem_addr         (mem_addr),
    .o_mem_data_in      (mem_data),
    .o_busy             (busy),
    .o_done             (done),
    .o_error            (error),
    .o_state            (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: captures the write port as the real memory would
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      tests_run++;
      if (mem_mode !== 1'b0) begin
        tests_failed++;
        $display("FAIL strobe_mode: mem_mode=%b during write, expected 0", mem_mode);
      end
      mem_model[mem_addr] = mem_data;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_data);
    end
  end

  // driver tasks
  task automatic clear_log();
    wr_addr_q  = {};
    wr_data_q  = {};
    exp_addr_q = {};
    exp_q      = {};
  endtask

  task automatic do_start(input logic [4:0] b, input logic [4:0] l);
    @(negedge clk);
    start = 1'b1; base_addr = b; load_len = l;
    @(negedge clk);
    start = 1'b0;
    tb_xor = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    byte_valid = 1'b1; byte_in = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL byte_timeout: byte_ready=%b after %0d cycles, expected 1", byte_ready, n);
    end
    @(posedge clk);
    tb_xor = tb_xor ^ b;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
  endtask

  task automatic stall(input int n);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // In checksum builds the load ends only after the checksum byte.
  task automatic finish_load();
`ifdef CHECKSUM_EN
    send_byte(tb_xor);
`endif
    stall(1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_timeout: done=%b, expected 1", done);
    end
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; load_len = '0;
    byte_in = '0; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests_run += 8;
    if (byte_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ready: got %b expected 0", byte_ready); end
    if (mem_mode !== 1'b1)   begin tests_failed++; $display("FAIL rst_mode: got %b expected 1", mem_mode); end
    if (mem_we !== 1'b0)     begin tests_failed++; $display("FAIL rst_we: got %b expected 0", mem_we); end
    if (mem_addr !== 5'd0)   begin tests_failed++; $display("FAIL rst_addr: got %h expected 0", mem_addr); end
    if (mem_data !== 32'd0)  begin tests_failed++; $display("FAIL rst_data: got %h expected 0", mem_data); end
    if (busy !== 1'b0)       begin tests_failed++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (done !== 1'b0)       begin tests_failed++; $display("FAIL rst_done: got %b expected 0", done); end
    if (error !== 1'b0)      begin tests_failed++; $display("FAIL rst_error: got %b expected 0", error); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] bytes [8];
    bytes = '{8'h00, 8'h22, 8'h00, 8'h00, 8'h04, 8'h41, 8'h00, 8'h00};
    clear_log();
    exp_addr_q = '{5'd0, 5'd1};
    exp_q      = '{32'h00220000, 32'h04410000};
    do_start(5'd0, 5'd2);
    tests_run += 2;
    if (busy !== 1'b1)     begin tests_failed++; $display("FAIL basic_busy: got %b expected 1", busy); end
    if (mem_mode !== 1'b0) begin tests_failed++; $display("FAIL basic_mode_load: got %b expected 0", mem_mode); end
    for (int i = 0; i < 4; i++) send_byte(bytes[i]);
    // strobe must be up for the cycle right after the 4th byte is taken
    @(negedge clk);
    tests_run += 4;
    if (mem_we !== 1'b1)            begin tests_failed++; $display("FAIL basic_latency_we: got %b expected 1", mem_we); end
    if (byte_ready !== 1'b0)        begin tests_failed++; $display("FAIL basic_latency_ready: got %b expected 0", byte_ready); end
    if (mem_addr !== 5'd0)          begin tests_failed++; $display("FAIL basic_latency_addr: got %h expected 0", mem_addr); end
    if (mem_data !== 32'h00220000)  begin tests_failed++; $display("FAIL basic_latency_data: got %h expected 00220000", mem_data); end
    for (int i = 4; i < 8; i++) send_byte(bytes[i]);
    finish_load();
    wait_done();
    tests_run += 4;
    if (busy !== 1'b0)     begin tests_failed++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    if (mem_mode !== 1'b1) begin tests_failed++; $display("FAIL basic_mode_fetch: got %b expected 1", mem_mode); end
    if (error !== 1'b0)    begin tests_failed++; $display("FAIL basic_error: got %b expected 0", error); end
    if (wr_addr_q.size() != 2) begin tests_failed++; $display("FAIL basic_count: got %0d writes expected 2", wr_addr_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
      tests_run += 2;
      if (wr_addr_q[i] !== exp_addr_q[i]) begin tests_failed++; $display("FAIL basic_wr_addr[%0d]: got %h expected %h", i, wr_addr_q[i], exp_addr_q[i]); end
      if (wr_data_q[i] !== exp_q[i])      begin tests_failed++; $display("FAIL basic_wr_data[%0d]: got %h expected %h", i, wr_data_q[i], exp_q[i]); end
    end
    tests_run += 2;
    if (mem_model[0] !== 32'h00220000) begin tests_failed++; $display("FAIL basic_fetch0: got %h expected 00220000", mem_model[0]); end
    if (mem_model[1] !== 32'h04410000) begin tests_failed++; $display("FAIL basic_fetch1: got %h expected 04410000", mem_model[1]); end
  endtask

  task automatic test_stall_and_restart();
    logic [7:0] bytes [8];
    bytes = '{8'h00, 8'h22, 8'h00, 8'h00, 8'h04, 8'h41, 8'h00, 8'h00};
    clear_log();
    exp_addr_q = '{5'd0, 5'd1};
    exp_q      = '{32'h00220000, 32'h04410000};
    do_start(5'd0, 5'd2);
    tests_run += 2;
    if (done !== 1'b0)  begin tests_failed++; $display("FAIL stall_done_clear: got %b expected 0", done); end
    if (error !== 1'b0) begin tests_failed++; $display("FAIL stall_error_clear: got %b expected 0", error); end
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i]);
      stall(3);
      if (i == 2) begin
        // a second start in the middle of the load must change nothing
        @(negedge clk);
        start = 1'b1; base_addr = 5'd7; load_len = 5'd3;
        @(negedge clk);
        start = 1'b0;
      end
    end
    finish_load();
    wait_done();
    tests_run++;
    if (wr_addr_q.size() != 2) begin tests_failed++; $display("FAIL stall_count: got %0d writes expected 2", wr_addr_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
      tests_run += 2;
      if (wr_addr_q[i] !== exp_addr_q[i]) begin tests_failed++; $display("FAIL stall_wr_addr[%0d]: got %h expected %h", i, wr_addr_q[i], exp_addr_q[i]); end
      if (wr_data_q[i] !== exp_q[i])      begin tests_failed++; $display("FAIL stall_wr_data[%0d]: got %h expected %h", i, wr_data_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    clear_log();
    exp_addr_q = '{5'd30, 5'd31, 5'd0, 5'd1};
    exp_q      = '{32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003};
    do_start(5'd30, 5'd4);
    for (int i = 0; i < 4; i++) send_word(exp_q[i]);
    finish_load();
    wait_done();
    tests_run++;
    if (wr_addr_q.size() != 4) begin tests_failed++; $display("FAIL wrap_count: got %0d writes expected 4", wr_addr_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
      tests_run += 2;
      if (wr_addr_q[i] !== exp_addr_q[i]) begin tests_failed++; $display("FAIL wrap_wr_addr[%0d]: got %h expected %h", i, wr_addr_q[i], exp_addr_q[i]); end
      if (wr_data_q[i] !== exp_q[i])      begin tests_failed++; $display("FAIL wrap_wr_data[%0d]: got %h expected %h", i, wr_data_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_full_depth();
    clear_log();
    for (int i = 0; i < 32; i++) begin
      exp_addr_q.push_back(5'((i + 5) % 32));
      exp_q.push_back(32'hC0DE0000 | 32'(i * 257));
    end
    do_start(5'd5, 5'd0);
    for (int i = 0; i < 32; i++) send_word(exp_q[i]);
    finish_load();
    wait_done();
    tests_run += 2;
    if (wr_addr_q.size() != 32) begin tests_failed++; $display("FAIL full_count: got %0d writes expected 32", wr_addr_q.size()); end
    if (wr_addr_q.size() > 0 && wr_addr_q[wr_addr_q.size()-1] !== 5'd4) begin
      tests_failed++; $display("FAIL full_last_addr: got %h expected 04", wr_addr_q[wr_addr_q.size()-1]);
    end
    for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
      tests_run += 2;
      if (wr_addr_q[i] !== exp_addr_q[i]) begin tests_failed++; $display("FAIL full_wr_addr[%0d]: got %h expected %h", i, wr_addr_q[i], exp_addr_q[i]); end
      if (wr_data_q[i] !== exp_q[i])      begin tests_failed++; $display("FAIL full_wr_data[%0d]: got %h expected %h", i, wr_data_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    mem_model[2] = 32'hDEADBEEF;
    do_start(5'd0, 5'd5);
    send_word(32'hA1A2A3A4);
    send_word(32'hB1B2B3B4);
    send_byte(8'hC1);
    @(negedge clk);
    byte_valid = 1'b1; byte_in = 8'hC2; rst_n = 1'b0;
    @(negedge clk);
    tests_run += 5;
    if (mem_mode !== 1'b1)   begin tests_failed++; $display("FAIL rmid_mode: got %b expected 1", mem_mode); end
    if (busy !== 1'b0)       begin tests_failed++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    if (byte_ready !== 1'b0) begin tests_failed++; $display("FAIL rmid_ready: got %b expected 0", byte_ready); end
    if (done !== 1'b0)       begin tests_failed++; $display("FAIL rmid_done: got %b expected 0", done); end
    if (mem_we !== 1'b0)     begin tests_failed++; $display("FAIL rmid_we: got %b expected 0", mem_we); end
    byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    tests_run += 4;
    if (wr_addr_q.size() != 2)         begin tests_failed++; $display("FAIL rmid_count: got %0d writes expected 2", wr_addr_q.size()); end
    if (mem_model[2] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rmid_addr2: got %h expected deadbeef", mem_model[2]); end
    if (mem_model[0] !== 32'hA1A2A3A4) begin tests_failed++; $display("FAIL rmid_addr0: got %h expected a1a2a3a4", mem_model[0]); end
    if (mem_model[1] !== 32'hB1B2B3B4) begin tests_failed++; $display("FAIL rmid_addr1: got %h expected b1b2b3b4", mem_model[1]); end
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] csums [2];
    logic       errs  [2];
    csums = '{8'h0F, 8'h0E};
    errs  = '{1'b0, 1'b1};
    for (int t = 0; t < 2; t++) begin
      clear_log();
      mem_model[9] = 32'h0;
      do_start(5'd9, 5'd1);
      send_word(32'h01020408);
      send_byte(csums[t]);
      stall(1);
      wait_done();
      tests_run += 4;
      if (error !== errs[t])                begin tests_failed++; $display("FAIL csum_error[%0d]: got %b expected %b", t, error, errs[t]); end
      if (busy !== 1'b0)                    begin tests_failed++; $display("FAIL csum_busy[%0d]: got %b expected 0", t, busy); end
      if (mem_mode !== 1'b1)                begin tests_failed++; $display("FAIL csum_mode[%0d]: got %b expected 1", t, mem_mode); end
      if (mem_model[9] !== 32'h01020408)    begin tests_failed++; $display("FAIL csum_word[%0d]: got %h expected 01020408", t, mem_model[9]); end
    end
  endtask
`endif

  initial begin
    tb_xor = 8'h00;
    for (int i = 0; i < 32; i++) mem_model[i] = 32'h0;
    test_reset();
    test_basic();
    test_stall_and_restart();
    test_wrap();
    test_full_depth();
    test_reset_mid_load();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader for the 32x32 instruction memory: the write-side counterpart of the fetch/decode path. Accepts a big-endian byte stream over a valid/ready handshake, packs 4 bytes per instruction word and drives the memory's write port (mode 0, write_enable, address, data_in) at consecutive addresses. Returns the memory to read/fetch mode (mode 1) when the load completes, so fetch can start at the loaded base address.

Parameters:
ADDR_WIDTH, 5, instruction memory address width; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, instruction word width; fixed at 4 bytes

Ports:
clock  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-low reset
start  input  1  begin a load; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first memory address to write; latched on start
load_len  input  ADDR_WIDTH  number of words to load; 0 means 2**ADDR_WIDTH; latched on start
byte_in  input  8  stream byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader accepts byte this cycle
mem_mode  output  1  to memory mode: 0 = load, 1 = read/fetch
mem_write_enable  output  1  memory write strobe
mem_addr  output  ADDR_WIDTH  memory address (PC input)
mem_data_in  output  DATA_WIDTH  word to write
busy  output  1  load in progress
done  output  1  last load completed; held until next accepted start
error  output  1  checksum mismatch (see Optional Feature); held until next accepted start

Behaviour:
- All outputs registered. Reset (reset==0 at posedge): state IDLE, byte_ready=0, mem_mode=1, mem_write_enable=0, mem_addr=0, mem_data_in=0, busy=0, done=0, error=0, internal counters 0.
- States: IDLE, RECV, WRITE, CHECK (CHECK only with CHECKSUM_EN).
- IDLE: byte_ready=0, mem_mode=1. start==1 -> latch base_addr, load_len; clear done/error; word_idx=0, byte_cnt=0; busy=1, mem_mode=0; -> RECV.
- start while busy is ignored.
- RECV: byte_ready=1. Byte transfer = byte_valid && byte_ready at posedge. Bytes packed MSB-first: byte 0 -> [31:24], byte 3 -> [7:0]. byte_valid low simply stalls; no timeout.
- On the 4th transfer -> WRITE; byte_ready drops in the same edge.
- WRITE (exactly 1 cycle): mem_write_enable=1, mem_addr=(base+word_idx) mod 2**ADDR_WIDTH, mem_data_in=packed word. The memory samples the write at the posedge ending this cycle. Latency: 4th byte accepted at edge N, write strobe high N..N+1.
- After WRITE:
  - if word_idx == len-1 (len=0 treated as 32): without feature -> IDLE with done=1, busy=0, mem_mode=1 on the same edge. With feature -> CHECK.
  - else word_idx+1, byte_cnt=0 -> RECV.
- mem_write_enable is never high outside WRITE; mem_mode=0 for the entire load.
- Address wrap: base 30, len 4 writes 30, 31, 0, 1. len=0 writes all 32 words, ending at base-1.
- Reset mid-load: abort immediately. No further writes, partial word discarded, outputs take reset values. Words already written remain in memory.
- Simultaneous byte_valid with the WRITE cycle: not accepted (byte_ready=0); the source holds the byte.

Optional Feature:
CHECKSUM_EN
- Defined: a running XOR of every data byte is accumulated (cleared on start). After the final WRITE, state CHECK asserts byte_ready=1 and accepts exactly one checksum byte. On acceptance: error=(byte != XOR), done=1, busy=0, mem_mode=1 -> IDLE. Words are already written regardless of error.
- Undefined: no CHECK state, no accumulator; error tied 0.

Test Plan:
- Basic load: start, base=0, len=2; bytes 00 22 00 00 04 41 00 00, byte_valid held high -> exactly two 1-cycle strobes: addr0=32'h00220000, addr1=32'h04410000; then done=1, busy=0, mem_mode=1; fetch reads back both words.
- Stalled stream: same data with byte_valid low 3 cycles between every byte, plus start pulsed again mid-load -> identical writes, no extra strobe, second start ignored.
- Wrap: base=30, len=4, words 32'h10000000..32'h10000003 -> writes in order at 30, 31, 0, 1.
- Full depth: base=5, len=0, 128 bytes -> 32 writes, last at address 4; done=1 after the 32nd.
- Reset mid-load: reset low during byte 2 of word 3 (base=0, len=5) -> no write to addr 2; mem_mode=1, busy=0, byte_ready=0, done=0; addrs 0-1 keep their loaded values.
- CHECKSUM_EN: len=1, bytes 01 02 04 08.
  - checksum 8'h0F -> error=0, done=1.
  - repeat with 8'h0E -> error=1, done=1.
  - word still written in both cases.
